// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one ALU between two requesters.
// Operands are registered, held for SETTLE cycles, then the result is sampled and returned.
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [3:0]       op0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [3:0]       op1,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [1:0]       grant;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle) begin
      if (req_valid == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    last_d     = last_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_out_d  = rsp_out_q;
    rsp_zero_d = rsp_zero_q;
    unique case (state_q)
      StIdle: begin
        if (grant != 2'b00) begin
          state_d = StIssue;
          cnt_d   = 4'd0;
          id_d    = grant[1];
          last_d  = grant[1];
          if (grant[1]) begin
            alu_a_d  = a1;
            alu_b_d  = b1;
            alu_op_d = op1;
          end else begin
            alu_a_d  = a0;
            alu_b_d  = b0;
            alu_op_d = op0;
          end
        end
      end
      StIssue: begin
        if (cnt_q == CntLast) begin
          state_d    = StResp;
          rsp_out_d  = alu_out;
          rsp_zero_d = alu_zero;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= 4'd0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      last_q     <= last_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_out_q  <= rsp_out_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == StResp) ? {id_q, ~id_q} : 2'b00;
  assign busy      = (state_q != StIdle);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned SETTLE = 2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [3:0]       op0, op1;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_zero;
  logic             busy;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  int checks;
  int failures;

  alu_share_arbiter #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .a0       (a0),
    .b0       (b0),
    .op0      (op0),
    .a1       (a1),
    .b1       (b1),
    .op1      (op1),
    .rsp_valid(rsp_valid),
    .rsp_out  (rsp_out),
    .rsp_zero (rsp_zero),
    .busy     (busy),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: AND, OR, ADD, SUB, SLT, NOR, otherwise pass A.
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == '0);
  end

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [3:0] op);
    if (id) begin
      a1 = a; b1 = b; op1 = op;
    end else begin
      a0 = a; b0 = b; op0 = op;
    end
    req_valid[id] = 1'b1;
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({busy, req_ready, rsp_valid, rsp_zero} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b ready=%b rsp_valid=%b zero=%b required all 0",
               busy, req_ready, rsp_valid, rsp_zero);
    end
    checks++;
    if (alu_a !== '0 || alu_b !== '0 || alu_op !== 4'd0 || rsp_out !== '0) begin
      failures++;
      $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%b rsp_out=%h required 0",
               alu_a, alu_b, alu_op, rsp_out);
    end
  endtask

  // Both held high from reset: grants 0,1,0 every 4 cycles; responses 3 cycles after each.
  task automatic test_rr_held();
    logic [1:0]       exp_rdy;
    logic [1:0]       exp_rsp;
    logic [WIDTH-1:0] exp_out;
    apply_reset();
    a0 = 64'hF0; b0 = 64'hFF; op0 = 4'b0000;
    a1 = 64'h0F; b1 = 64'h0F; op1 = 4'b0000;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rdy = 2'b00;
      exp_rsp = 2'b00;
      if (c % 4 == 0) exp_rdy = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      if (c % 4 == 3) exp_rsp = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      exp_out = ((c / 4) % 2 == 0) ? 64'hF0 : 64'h0F;
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rr_ready c=%0d: got %b required %b", c, req_ready, exp_rdy);
      end
      checks++;
      if (rsp_valid !== exp_rsp) begin
        failures++;
        $display("FAIL rr_rsp_valid c=%0d: got %b required %b", c, rsp_valid, exp_rsp);
      end
      if (c % 4 == 3) begin
        checks++;
        if (rsp_out !== exp_out) begin
          failures++;
          $display("FAIL rr_rsp_out c=%0d: got %h required %h", c, rsp_out, exp_out);
        end
      end
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_single_add();
    apply_reset();
    drive(1'b0, 64'd5, 64'd7, 4'b0010);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL add_ready: got %b required 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (alu_a !== 64'd5 || alu_b !== 64'd7 || alu_op !== 4'b0010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_issue: alu_a=%h alu_b=%h op=%b busy=%b required 5 7 0010 1",
               alu_a, alu_b, alu_op, busy);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || alu_a !== 64'd5) begin
      failures++;
      $display("FAIL add_hold: rsp_valid=%b alu_a=%h required 00 5", rsp_valid, alu_a);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_out !== 64'd12 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL add_rsp: rsp_valid=%b out=%h zero=%b required 01 c 0",
               rsp_valid, rsp_out, rsp_zero);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_out !== 64'd12 || alu_a !== 64'd5) begin
      failures++;
      $display("FAIL add_after: rsp_valid=%b busy=%b out=%h alu_a=%h required 00 0 c 5",
               rsp_valid, busy, rsp_out, alu_a);
    end
  endtask

  task automatic test_sub_zero();
    tick();
    drive(1'b1, 64'd9, 64'd9, 4'b0110);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL sub_ready: got %b required 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_out !== '0 || rsp_zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_rsp: rsp_valid=%b out=%h zero=%b required 10 0 1",
               rsp_valid, rsp_out, rsp_zero);
    end
    tick();
  endtask

  task automatic test_req_in_resp();
    tick();
    drive(1'b0, 64'd1, 64'd2, 4'b0001);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    drive(1'b1, 64'h30, 64'h0C, 4'b0001);
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_out !== 64'd3 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL resp_cycle: rsp_valid=%b out=%h ready=%b required 01 3 00",
               rsp_valid, rsp_out, req_ready);
    end
    tick();
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL resp_next_idle_ready: got %b required 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_out !== 64'h3C) begin
      failures++;
      $display("FAIL resp_late_rsp: rsp_valid=%b out=%h required 10 3c", rsp_valid, rsp_out);
    end
    tick();
  endtask

  task automatic test_opcodes();
    tick();
    drive(1'b0, 64'd3, 64'd4, 4'b1111);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_out !== 64'd3 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL op_unlisted: rsp_valid=%b out=%h zero=%b required 01 3 0",
               rsp_valid, rsp_out, rsp_zero);
    end
    tick();
    drive(1'b1, 64'd0, 64'd0, 4'b1100);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_out !== {WIDTH{1'b1}} || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL op_nor: rsp_valid=%b out=%h zero=%b required 10 all-ones 0",
               rsp_valid, rsp_out, rsp_zero);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    tick();
    drive(1'b0, 64'd5, 64'd7, 4'b0010);
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (busy !== 1'b1 || alu_a !== 64'd5) begin
      failures++;
      $display("FAIL midrst_pre: busy=%b alu_a=%h required 1 5", busy, alu_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00 || alu_a !== '0 || alu_b !== '0
        || alu_op !== 4'd0 || rsp_out !== '0) begin
      failures++;
      $display("FAIL midrst_async: busy=%b rsp_valid=%b alu_a=%h alu_b=%h op=%b out=%h req 0",
               busy, rsp_valid, alu_a, alu_b, alu_op, rsp_out);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL midrst_quiet c=%0d: rsp_valid=%b busy=%b required 00 0",
                 c, rsp_valid, busy);
      end
      tick();
    end
    // last returns to 1, so requester 0 wins a tie again.
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL midrst_tie: got %b required 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    a0 = '0; b0 = '0; op0 = 4'd0;
    a1 = '0; b1 = '0; op1 = 4'd0;
    test_reset();
    test_rr_held();
    test_single_add();
    test_sub_zero();
    test_req_in_resp();
    test_opcodes();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
